// File: rtl/wr_fram_pack_buf.sv
// wr_fram_pack_buf
//   Write-side frame buffer. Packs RATIO = RD_DATA_WIDTH/WR_DATA_WIDTH narrow
//   pixel words (LSB lane first) into one wide word. Wide words are kept in a
//   circular buffer of DEPTH = 2**RD_ADDR_WIDTH entries. burst_ready tells the
//   DDR write master when a full burst, or an end-of-frame remainder, can be
//   drained.
//
//   Optional feature macro: WR_FRAM_PACK_BUF_DROP_CNT_EN
//     When defined, adds drop_cnt[15:0], a saturating count of dropped wide words.
//
// Ports
//   wr_clk       sole clock
//   wr_rst       asynchronous active-high reset
//   frame_start  start-of-frame pulse; clears lane, pointers, count, flags
//   frame_end    marks the last input word; flushes a partial wide word
//   wr_en        wr_data valid
//   wr_data      narrow pixel word
//   wr_full      buffer holds DEPTH wide words
//   rd_en        pop one wide word
//   rd_data      popped wide word (registered, 1-cycle latency)
//   rd_valid     rd_data valid this cycle
//   burst_ready  burst or flush remainder available
//   word_cnt     wide words stored
//   overflow     sticky: a wide word was dropped
//   drop_cnt     (optional) dropped wide word count
module wr_fram_pack_buf #(
  parameter int WR_DATA_WIDTH = 32,
  parameter int RD_DATA_WIDTH = 128,
  parameter int RD_ADDR_WIDTH = 8,
  parameter int BURST_LEN     = 16
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_full,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     burst_ready,
  output logic [RD_ADDR_WIDTH:0]   word_cnt,
`ifdef WR_FRAM_PACK_BUF_DROP_CNT_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic                     overflow
);

  localparam int RATIO  = RD_DATA_WIDTH / WR_DATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH  = 2 ** RD_ADDR_WIDTH;
  localparam logic [LANE_W:0]        RATIO_C = (LANE_W + 1)'(RATIO);
  localparam logic [RD_ADDR_WIDTH:0] DEPTH_C = (RD_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [RD_ADDR_WIDTH:0] BURST_C = (RD_ADDR_WIDTH + 1)'(BURST_LEN);

  logic [RD_DATA_WIDTH-1:0] mem [DEPTH];

  logic [LANE_W-1:0]        lane_reg;
  logic [RD_DATA_WIDTH-1:0] pack_reg;
  logic [RD_ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [RD_ADDR_WIDTH:0]   cnt_reg;
  logic                     flush_pend_reg, overflow_reg, rd_valid_reg;
  logic [RD_DATA_WIDTH-1:0] rd_data_reg;

  // frame_start restarts the frame in the same cycle, so all next-state math
  // starts from a "base" view that is already cleared when it is asserted.
  logic [LANE_W-1:0]        lane_base;
  logic [RD_DATA_WIDTH-1:0] pack_base, pack_ins;
  logic [RD_ADDR_WIDTH-1:0] wr_ptr_base, rd_ptr_base;
  logic [RD_ADDR_WIDTH:0]   cnt_base;
  logic [LANE_W:0]          lane_inc;
  logic                     commit, pop, accept, drop;

  assign lane_base   = frame_start ? '0 : lane_reg;
  assign pack_base   = frame_start ? '0 : pack_reg;
  assign wr_ptr_base = frame_start ? '0 : wr_ptr_reg;
  assign rd_ptr_base = frame_start ? '0 : rd_ptr_reg;
  assign cnt_base    = frame_start ? '0 : cnt_reg;

  // Insert the incoming word into its lane; other lanes keep pack contents,
  // which are zero above the fill point because pack_reg clears on commit.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign pack_ins[gi*WR_DATA_WIDTH +: WR_DATA_WIDTH] =
      (wr_en && lane_base == LANE_W'(gi)) ? wr_data
                                          : pack_base[gi*WR_DATA_WIDTH +: WR_DATA_WIDTH];
  end

  assign lane_inc = {1'b0, lane_base} + {{LANE_W{1'b0}}, wr_en};
  // Full word completed, or end of frame with a partial word pending.
  assign commit   = (lane_inc == RATIO_C) || (frame_end && lane_inc != '0);
  assign pop      = !frame_start && rd_en && (cnt_reg != '0);
  // A same-cycle pop frees a slot, so a commit at full is still accepted.
  assign accept   = commit && ((cnt_base != DEPTH_C) || pop);
  assign drop     = commit && !accept;

  always_ff @(posedge wr_clk) begin
    if (accept) mem[wr_ptr_base] <= pack_ins;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      lane_reg       <= '0;
      pack_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
    end else begin
      lane_reg   <= commit ? '0 : lane_inc[LANE_W-1:0];
      pack_reg   <= commit ? '0 : pack_ins;
      wr_ptr_reg <= accept ? wr_ptr_base + 1'b1 : wr_ptr_base;
      rd_ptr_reg <= pop ? rd_ptr_base + 1'b1 : rd_ptr_base;
      case ({accept, pop})
        2'b10:   cnt_reg <= cnt_base + 1'b1;
        2'b01:   cnt_reg <= cnt_base - 1'b1;
        default: cnt_reg <= cnt_base;
      endcase
      if (frame_end)
        flush_pend_reg <= 1'b1;
      else if (frame_start || (cnt_base == '0 && !accept) ||
               (cnt_base == 1 && pop && !accept))
        flush_pend_reg <= 1'b0;
      overflow_reg <= (frame_start ? 1'b0 : overflow_reg) | drop;
      rd_valid_reg <= pop;
      if (pop) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

`ifdef WR_FRAM_PACK_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_reg;
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst)
      drop_cnt_reg <= '0;
    else if (frame_start)
      drop_cnt_reg <= {15'd0, drop};
    else if (drop && drop_cnt_reg != 16'hFFFF)
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end
  assign drop_cnt = drop_cnt_reg;
`endif

  assign word_cnt    = cnt_reg;
  assign wr_full     = (cnt_reg == DEPTH_C);
  assign overflow    = overflow_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_data     = rd_data_reg;
  assign burst_ready = (cnt_reg >= BURST_C) || (flush_pend_reg && cnt_reg != '0);

endmodule

// File: tb/tb_wr_fram_pack_buf.sv
// Directed testbench for wr_fram_pack_buf at default parameters
// (RATIO=4, DEPTH=256, BURST_LEN=16).
module tb_wr_fram_pack_buf;

  logic         wr_clk;
  logic         wr_rst;
  logic         frame_start;
  logic         frame_end;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic         wr_full;
  logic         rd_en;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         burst_ready;
  logic [8:0]   word_cnt;
  logic         overflow;
`ifdef WR_FRAM_PACK_BUF_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wr_fram_pack_buf dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .burst_ready (burst_ready),
    .word_cnt    (word_cnt),
`ifdef WR_FRAM_PACK_BUF_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .overflow    (overflow)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  task automatic cycle();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic push(input int data, input logic fe);
    wr_en = 1'b1;
    wr_data = 32'(data);
    frame_end = fe;
    cycle();
    wr_en = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  function automatic logic [127:0] word4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic test_reset();
    #200;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    checks++; if (rd_data !== 128'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got %0b want 0", wr_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL reset_burst_ready got %0b want 0", burst_ready); end
    wr_rst = 1'b0;
    repeat (10) cycle();
    checks++; if (word_cnt !== 9'd0) begin errors++; $display("FAIL idle_word_cnt got %0d want 0", word_cnt); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL idle_burst_ready got %0b want 0", burst_ready); end
    $display("test_reset done");
  endtask

  task automatic test_burst_fill();
    logic [127:0] exp;
    start_frame();
    for (int i = 1; i <= 63; i++) push(i, 1'b0);
    checks++; if (word_cnt !== 9'd15) begin errors++; $display("FAIL fill63_word_cnt got %0d want 15", word_cnt); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL fill63_burst_ready got %0b want 0", burst_ready); end
    push(64, 1'b0);
    checks++; if (word_cnt !== 9'd16) begin errors++; $display("FAIL fill64_word_cnt got %0d want 16", word_cnt); end
    checks++; if (burst_ready !== 1'b1) begin errors++; $display("FAIL fill64_burst_ready got %0b want 1", burst_ready); end
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      exp = word4(4*k+1, 4*k+2, 4*k+3, 4*k+4);
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL burst_rd_valid[%0d] got %0b want 1", k, rd_valid); end
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL burst_rd_data[%0d] got %h want %h", k, rd_data, exp); end
    end
    rd_en = 1'b0;
    cycle();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL burst_end_rd_valid got %0b want 0", rd_valid); end
    checks++; if (word_cnt !== 9'd0) begin errors++; $display("FAIL burst_end_word_cnt got %0d want 0", word_cnt); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL burst_end_burst_ready got %0b want 0", burst_ready); end
    $display("test_burst_fill done");
  endtask

  task automatic test_flush();
    logic [127:0] exp;
    start_frame();
    for (int i = 1; i <= 5; i++) push(i, 1'b0);
    push(6, 1'b1);
    checks++; if (word_cnt !== 9'd2) begin errors++; $display("FAIL flush_word_cnt got %0d want 2", word_cnt); end
    checks++; if (burst_ready !== 1'b1) begin errors++; $display("FAIL flush_burst_ready got %0b want 1", burst_ready); end
    rd_en = 1'b1;
    cycle();
    exp = word4(1, 2, 3, 4);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL flush_word0 got %h want %h", rd_data, exp); end
    cycle();
    rd_en = 1'b0;
    exp = word4(5, 6, 0, 0);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL flush_word1 got %h want %h", rd_data, exp); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL flush_empty_burst_ready got %0b want 0", burst_ready); end
    // flush_pend must have cleared: one fresh wide word is not a burst.
    for (int i = 7; i <= 10; i++) push(i, 1'b0);
    checks++; if (word_cnt !== 9'd1) begin errors++; $display("FAIL flush_after_word_cnt got %0d want 1", word_cnt); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL flush_pend_clear got %0b want 0", burst_ready); end
    $display("test_flush done");
  endtask

  task automatic test_overflow();
    logic [127:0] exp;
    start_frame();
    for (int i = 1; i <= 1024; i++) push(i, 1'b0);
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL ovf_wr_full got %0b want 1", wr_full); end
    checks++; if (word_cnt !== 9'd256) begin errors++; $display("FAIL ovf_word_cnt got %0d want 256", word_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", overflow); end
    for (int i = 1025; i <= 1028; i++) push(i, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
    checks++; if (word_cnt !== 9'd256) begin errors++; $display("FAIL ovf_drop_word_cnt got %0d want 256", word_cnt); end
`ifdef WR_FRAM_PACK_BUF_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
`endif
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    exp = word4(1, 2, 3, 4);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovf_no_overwrite got %h want %h", rd_data, exp); end
    checks++; if (word_cnt !== 9'd255) begin errors++; $display("FAIL ovf_pop_word_cnt got %0d want 255", word_cnt); end
    start_frame();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    checks++; if (word_cnt !== 9'd0) begin errors++; $display("FAIL ovf_clear_word_cnt got %0d want 0", word_cnt); end
`ifdef WR_FRAM_PACK_BUF_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL ovf_drop_cnt_clear got %0d want 0", drop_cnt); end
`endif
    $display("test_overflow done");
  endtask

  task automatic test_simultaneous();
    logic [127:0] exp;
    start_frame();
    for (int i = 1; i <= 43; i++) push(i, 1'b0);
    rd_en = 1'b1;
    push(44, 1'b0);
    rd_en = 1'b0;
    checks++; if (word_cnt !== 9'd10) begin errors++; $display("FAIL sim10_word_cnt got %0d want 10", word_cnt); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL sim10_rd_valid got %0b want 1", rd_valid); end
    start_frame();
    for (int i = 1; i <= 1027; i++) push(i, 1'b0);
    rd_en = 1'b1;
    push(1028, 1'b0);
    rd_en = 1'b0;
    exp = word4(1, 2, 3, 4);
    checks++; if (word_cnt !== 9'd256) begin errors++; $display("FAIL simfull_word_cnt got %0d want 256", word_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simfull_overflow got %0b want 0", overflow); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL simfull_rd_data got %h want %h", rd_data, exp); end
    $display("test_simultaneous done");
  endtask

  task automatic test_async_reset();
    start_frame();
    for (int i = 1; i <= 80; i++) push(i, 1'b0);
    rd_en = 1'b1;
    cycle();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_rd_valid got %0b want 1", rd_valid); end
    #2;
    wr_rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd_valid got %0b want 0", rd_valid); end
    checks++; if (burst_ready !== 1'b0) begin errors++; $display("FAIL arst_burst_ready got %0b want 0", burst_ready); end
    checks++; if (word_cnt !== 9'd0) begin errors++; $display("FAIL arst_word_cnt got %0d want 0", word_cnt); end
    rd_en = 1'b0;
    cycle();
    wr_rst = 1'b0;
    cycle();
    $display("test_async_reset done");
  endtask

  initial begin
    wr_rst = 1'b1;
    frame_start = 1'b0;
    frame_end = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    rd_en = 1'b0;
    test_reset();
    test_burst_fill();
    test_flush();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_fram_pack_buf.md
Name: wr_fram_pack_buf

Overview:
- Single-clock, parametrised successor to the write-side frame buffer.
- Accepts narrow pixel words and packs RATIO = RD_DATA_WIDTH/WR_DATA_WIDTH of them, LSB-first, into wide words.
- Stores wide words in an internal circular buffer and tells the DDR write master when a full burst, or an end-of-frame remainder, is ready.
- Adds frame-aligned clearing, zero-padded flush and overflow detection.

Parameters:
WR_DATA_WIDTH, 32, narrow input word width.
RD_DATA_WIDTH, 128, wide output word width; an integer power-of-two multiple of WR_DATA_WIDTH (RATIO >= 1).
RD_ADDR_WIDTH, 8, buffer depth DEPTH = 2**RD_ADDR_WIDTH wide words.
BURST_LEN, 16, wide words per DDR burst; 1 <= BURST_LEN <= DEPTH.

Ports:
wr_clk  in  1  sole clock.
wr_rst  in  1  asynchronous, active-high reset.
frame_start  in  1  single-cycle pulse at start of frame.
frame_end  in  1  single-cycle pulse qualifying the last input word of a frame.
wr_en  in  1  input word valid.
wr_data  in  WR_DATA_WIDTH  input pixel word.
wr_full  out  1  buffer holds DEPTH wide words.
rd_en  in  1  DDR master pops one wide word.
rd_data  out  RD_DATA_WIDTH  popped wide word.
rd_valid  out  1  rd_data valid this cycle.
burst_ready  out  1  a burst (or flush remainder) is available.
word_cnt  out  RD_ADDR_WIDTH+1  wide words currently stored.
overflow  out  1  sticky: a wide word was dropped.

Behaviour:
- Interface: one clock, wr_clk; reset wr_rst is asynchronous and active-high.
- Reset values: all outputs 0; lane index, pointers, flush_pend and internal state cleared.
- Packing:
  - A lane counter runs 0..RATIO-1. wr_en stores wr_data at bits [lane*WR_DATA_WIDTH +: WR_DATA_WIDTH] of the pack register.
  - When wr_en occurs at lane RATIO-1, the completed wide word commits to buffer[wr_ptr] at that edge; wr_ptr++ and lane wraps to 0.
  - RATIO=1: every wr_en commits.
- Full/overflow:
  - wr_full = (word_cnt == DEPTH).
  - A commit while full is dropped: wr_ptr and word_cnt unchanged, overflow set to 1.
  - overflow is sticky until frame_start or reset.
- Read:
  - rd_en with word_cnt != 0 pops buffer[rd_ptr]; rd_ptr++.
  - rd_data and rd_valid are registered: 1-cycle latency after the rd_en edge.
  - rd_en while empty is ignored, rd_valid=0, rd_data holds its last value.
- Count: word_cnt = commits - pops. A simultaneous commit and pop leaves word_cnt unchanged, including at full: a pop at full frees space, so the commit is accepted.
- Pointers: wrap modulo DEPTH.
- Flush:
  - frame_end takes effect at the same edge as any coincident wr_en, which is included first.
  - If lane != 0 after that, the partial word commits with unused upper lanes zero; lane returns to 0.
  - frame_end sets flush_pend. flush_pend clears when word_cnt becomes 0, or on frame_start.
- burst_ready = (word_cnt >= BURST_LEN) || (flush_pend && word_cnt != 0). Combinational from registered state.
- frame_start has priority over everything else:
  - Synchronously clears lane, pointers, word_cnt, flush_pend and overflow.
  - A coincident wr_en is stored as lane 0 of the new frame.
  - A coincident rd_en is ignored.
  - frame_start and frame_end in the same cycle: frame_start wins, then the coincident word is flushed as a single padded wide word.
- Mid-operation reset: asynchronously clears all state. rd_valid and burst_ready drop immediately, without waiting for a clock edge.

Optional Feature:
Macro WR_FRAM_PACK_BUF_DROP_CNT_EN.
- Defined: extra output drop_cnt [15:0] counts dropped wide words.
  - Saturates at 0xFFFF.
  - Cleared by reset and frame_start.
  - Increments at the same edge as overflow.
- Undefined: no drop_cnt port and no counter logic; only the sticky overflow flag exists.

Test Plan (defaults, RATIO=4, DEPTH=256):
1. Reset: hold wr_rst 200 ns -> all outputs 0. Release, idle 10 cycles -> word_cnt=0, burst_ready=0.
2. Burst fill: frame_start, then 64 wr_en with data 1..64 -> burst_ready rises the cycle after word 64, word_cnt=16. Then 16 rd_en -> first rd_data = 0x00000004_00000003_00000002_00000001 with rd_valid one cycle after the first rd_en; word_cnt=0 and burst_ready=0 at the end.
3. Flush: write 6 words (1..6), frame_end with word 6 -> word_cnt=2, burst_ready=1. Second popped word = 0x00000000_00000000_00000006_00000005. flush_pend clears once empty.
4. Overflow: write 1028 words with no reads -> wr_full=1 after word 1024, word_cnt=256, word 257 dropped, overflow=1 (drop_cnt=1 if enabled). frame_start -> overflow=0, word_cnt=0.
5. Simultaneous events: at word_cnt=10, a commit and rd_en in the same cycle -> word_cnt stays 10. At word_cnt=256, the same -> word_cnt 256, overflow stays 0.
6. Async reset mid-burst: assert wr_rst between clock edges during rd_en streaming -> rd_valid, burst_ready and word_cnt go 0 before the next wr_clk edge.
